// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state numbering (common to TX and RX), frame
// width, parity select codes and the parity check helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b010,
      ST_PARITY = 3'b011,
      ST_STOP   = 3'b100
   } uart_state_t;

   localparam logic PARITY_SEL_EVEN = 1'b0;
   localparam logic PARITY_SEL_ODD  = 1'b1;

   function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                         input logic                 par_bit,
                                         input logic                 odd_sel);
      return (^data ^ par_bit) ^ odd_sel;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// come out of reset at RESET_VAL so an idle-high line reads idle immediately.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync;

   // NOTE: non-blocking assignments so both stages shift on the same edge.
   always_ff @(posedge clk) begin
      if (rst) sync <= {2{RESET_VAL}};
      else     sync <= {sync[0], d};
   end

   assign q = sync[1];

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled start/8 data/parity/stop frame recovery with
// parity and framing checks; each byte is presented with a one-clk strobe.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int               CNT_W   = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]       BIT_END = 3'(DATA_BITS - 1);
   localparam logic             PAR_SEL = PARITY_ODD ? PARITY_SEL_ODD : PARITY_SEL_EVEN;

   logic                 rxs;
   uart_state_t          state;
   logic                 armed;
   logic [CNT_W-1:0]     tick_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_pend;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         armed        <= 1'b0;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_err_pend <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (sample_tick) begin
            case (state)
               ST_IDLE: begin
                  // A start edge counts only after the line was seen high.
                  if (rxs) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state    <= ST_START;
                     tick_cnt <= '0;
                     rx_busy  <= 1'b1;
                  end
               end
               ST_START: begin
                  if (tick_cnt == CNT_MID) begin
                     tick_cnt <= '0;
                     if (!rxs) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                     end else begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == CNT_END) begin
                     shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_END) state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == CNT_END) begin
                     par_err_pend <= parity_error(shreg, rxs, PAR_SEL);
                     state        <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == CNT_END) begin
                     rx_data    <= shreg;
                     parity_err <= par_err_pend;
                     frame_err  <= ~rxs;
                     rx_valid   <= 1'b1;
                     rx_busy    <= 1'b0;
                     state      <= ST_IDLE;
                     // Low stop bit: wait for the line to return high first.
                     if (!rxs) armed <= 1'b0;
                  end
               end
               default: begin
                  state      <= ST_IDLE;
                  tick_cnt   <= '0;
                  bit_cnt    <= '0;
                  rx_data    <= '0;
                  parity_err <= 1'b0;
                  frame_err  <= 1'b0;
                  rx_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a table of whole frames plus hand-written
// sequences for timing, false start, stuck-low line, back-to-back and reset.
module tb_uart_rx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic       rxd;
   logic [7:0] rx_data,  rx_data_o;
   logic       rx_valid, rx_valid_o;
   logic       parity_err, parity_err_o;
   logic       frame_err,  frame_err_o;
   logic       rx_busy,    rx_busy_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         vcyc[$];
   logic [7:0] vdata[$];
   int         odd_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_fsm #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
      .frame_err(frame_err), .rx_busy(rx_busy)
   );

   uart_rx_fsm #(.OVERSAMPLE(16), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd),
      .rx_data(rx_data_o), .rx_valid(rx_valid_o), .parity_err(parity_err_o),
      .frame_err(frame_err_o), .rx_busy(rx_busy_o)
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         vcyc.push_back(cyc);
         vdata.push_back(rx_data);
      end
      if (rx_valid_o) odd_cnt++;
   end

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_perr_odd;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic b, input int n);
      rxd = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(d[i], 16);
      hold(par, 16);
      hold(stop, 16);
   endtask

   initial begin
      int n0, c0, got, ncheck;
      logic [7:0] fr;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h6B, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; rxd = 1'b1; sample_tick = 1'b1;
      repeat (3) @(negedge clk);
      check("reset rx_data", 32'(rx_data), 32'h0);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset parity_err", 32'(parity_err), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset rx_busy", 32'(rx_busy), 32'h0);
      rst = 1'b0;
      hold(1'b1, 10);

      // Start edge reaches the FSM 3 edges after it is driven; stop is sampled 168 ticks later.
      n0 = vcyc.size();
      c0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1);
      hold(1'b1, 8);
      check("a5 valid count", 32'(vcyc.size() - n0), 32'd1);
      got = (vcyc.size() > n0) ? vcyc[n0] - c0 : -1;
      check("a5 valid latency", 32'(got), 32'd171);
      check("a5 rx_data", 32'(rx_data), 32'hA5);

      foreach (vecs[k]) begin
         n0 = vcyc.size();
         ncheck = odd_cnt;
         send_frame(vecs[k].data, vecs[k].par, vecs[k].stop);
         hold(1'b1, 8);
         check($sformatf("vec%0d valid count", k), 32'(vcyc.size() - n0), 32'd1);
         check($sformatf("vec%0d rx_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
         check($sformatf("vec%0d parity_err", k), 32'(parity_err), 32'(vecs[k].exp_perr));
         check($sformatf("vec%0d frame_err", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
         check($sformatf("vec%0d odd valid count", k), 32'(odd_cnt - ncheck), 32'd1);
         check($sformatf("vec%0d odd rx_data", k), 32'(rx_data_o), 32'(vecs[k].exp_data));
         check($sformatf("vec%0d odd parity_err", k), 32'(parity_err_o), 32'(vecs[k].exp_perr_odd));
      end

      // Glitch: 4 ticks low is gone by the mid-start sample at tick 8.
      n0 = vcyc.size();
      rxd = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 4) rxd = 1'b1;
         if (i == 2)  check("glitch busy before detect", 32'(rx_busy), 32'd0);
         if (i == 3)  check("glitch busy at tick 0", 32'(rx_busy), 32'd1);
         if (i == 10) check("glitch busy at tick 7", 32'(rx_busy), 32'd1);
         if (i == 11) check("glitch busy after tick 8", 32'(rx_busy), 32'd0);
      end
      hold(1'b1, 200);
      check("glitch no valid", 32'(vcyc.size() - n0), 32'd0);
      check("glitch rx_data held", 32'(rx_data), 32'h01);

      // Back-to-back: a frame spans 11 bits of 16 ticks, so strobes are 176 ticks apart.
      n0 = vcyc.size();
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);
      hold(1'b1, 8);
      check("b2b valid count", 32'(vcyc.size() - n0), 32'd2);
      got = (vcyc.size() > n0 + 1) ? vcyc[n0+1] - vcyc[n0] : -1;
      check("b2b spacing", 32'(got), 32'd176);
      check("b2b first data", 32'((vdata.size() > n0) ? vdata[n0] : 8'hxx), 32'h55);
      check("b2b second data", 32'((vdata.size() > n0 + 1) ? vdata[n0+1] : 8'hxx), 32'hAA);

      // Stop bit low, line stuck low, then a clean frame.
      n0 = vcyc.size();
      send_frame(8'h3C, 1'b0, 1'b0);
      hold(1'b0, 40);
      check("stuck valid count", 32'(vcyc.size() - n0), 32'd1);
      check("stuck rx_data", 32'(rx_data), 32'h3C);
      check("stuck frame_err", 32'(frame_err), 32'd1);
      check("stuck parity_err", 32'(parity_err), 32'd0);
      hold(1'b1, 16);
      send_frame(8'hC3, 1'b0, 1'b1);
      hold(1'b1, 8);
      check("recover valid count", 32'(vcyc.size() - n0), 32'd2);
      check("recover rx_data", 32'(rx_data), 32'hC3);
      check("recover parity_err", 32'(parity_err), 32'd0);
      check("recover frame_err", 32'(frame_err), 32'd0);

      // Leave parity_err set so the reset is visible on every output.
      send_frame(8'h01, 1'b0, 1'b1);
      hold(1'b1, 8);
      check("pre-reset parity_err", 32'(parity_err), 32'd1);

      // Reset at tick 80 of a frame (drive-relative cycle 83).
      n0 = vcyc.size();
      fr = 8'h7E;
      for (int t = 0; t < 84; t++) begin
         if (t < 16) rxd = 1'b0;
         else        rxd = fr[(t - 16) / 16];
         rst = (t == 83);
         @(negedge clk);
      end
      check("midreset rx_data", 32'(rx_data), 32'h0);
      check("midreset rx_valid", 32'(rx_valid), 32'h0);
      check("midreset parity_err", 32'(parity_err), 32'h0);
      check("midreset frame_err", 32'(frame_err), 32'h0);
      check("midreset rx_busy", 32'(rx_busy), 32'h0);
      rst = 1'b0;
      hold(1'b1, 30);
      check("midreset no valid", 32'(vcyc.size() - n0), 32'd0);
      send_frame(8'h7E, 1'b0, 1'b1);
      hold(1'b1, 8);
      check("post-reset valid count", 32'(vcyc.size() - n0), 32'd1);
      check("post-reset rx_data", 32'(rx_data), 32'h7E);
      check("post-reset parity_err", 32'(parity_err), 32'd0);
      check("post-reset frame_err", 32'(frame_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
